// File: rtl/me_min_select_if.sv
// Handshake/result bundle between the PE array bus, the min-select stage and the frame sequencer.
interface me_min_select_if #(
  parameter int NPE    = 16,
  parameter int DIST_W = 16,
  parameter int VEC_W  = 4
);
  logic              compstart;
  logic [NPE-1:0]    peready;
  logic [DIST_W-1:0] dist_in;
  logic [VEC_W-1:0]  vectorx;
  logic [VEC_W-1:0]  vectory;
  logic [DIST_W-1:0] best_dist;
  logic [VEC_W-1:0]  motionx;
  logic [VEC_W-1:0]  motiony;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output compstart, peready, dist_in, vectorx, vectory,
    input  best_dist, motionx, motiony, busy, done, err
  );

  modport slave (
    input  compstart, peready, dist_in, vectorx, vectory,
    output best_dist, motionx, motiony, busy, done, err
  );
endinterface

// File: rtl/me_min_select.sv
// Minimum-distortion tracker over one full-search window; reports best motion vector with a done pulse.
// Optional macro ME_TIE_CLOSEST_EN: on equal distortion prefer the candidate with smaller |x|+|y|.
module me_min_select #(
  parameter int NPE      = 16,
  parameter int DIST_W   = 16,
  parameter int VEC_W    = 4,
  parameter int NUM_CAND = 256
) (
  input logic            clock,
  input logic            reset,
  me_min_select_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_CAND) + 1;

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic              rearm_wait;
  logic              s1_valid;
  logic [DIST_W-1:0] s1_dist;
  logic [VEC_W-1:0]  s1_x;
  logic [VEC_W-1:0]  s1_y;
  logic              onehot;
  logic              multihot;
  logic              accept;
  logic              better;

`ifdef ME_TIE_CLOSEST_EN
  function automatic logic [VEC_W:0] mag(input logic [VEC_W-1:0] v);
    logic [VEC_W:0] e;
    e = {v[VEC_W-1], v};
    return e[VEC_W] ? -e : e;
  endfunction
`endif

  always_comb begin
    onehot   = (bus.peready != '0) && ((bus.peready & (bus.peready - NPE'(1))) == '0);
    multihot = (bus.peready != '0) && !onehot;
    // A falling compstart wins over a same-cycle strobe.
    accept   = onehot && (state == SEARCH) && bus.compstart && (count < CNT_W'(NUM_CAND));
`ifdef ME_TIE_CLOSEST_EN
    better   = (s1_dist < bus.best_dist) ||
               ((s1_dist == bus.best_dist) &&
                (((VEC_W+2)'(mag(s1_x)) + (VEC_W+2)'(mag(s1_y))) <
                 ((VEC_W+2)'(mag(bus.motionx)) + (VEC_W+2)'(mag(bus.motiony)))));
`else
    better   = s1_dist < bus.best_dist;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      rearm_wait    <= 1'b0;
      s1_valid      <= 1'b0;
      s1_dist       <= '0;
      s1_x          <= '0;
      s1_y          <= '0;
      bus.best_dist <= '1;
      bus.motionx   <= '0;
      bus.motiony   <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_dist <= bus.dist_in;
        s1_x    <= bus.vectorx;
        s1_y    <= bus.vectory;
        count   <= count + CNT_W'(1);
      end
      bus.done <= 1'b0;
      // After a completed search, compstart must drop before another start is honoured.
      if (!bus.compstart) rearm_wait <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.compstart && !rearm_wait) begin
            state         <= SEARCH;
            bus.busy      <= 1'b1;
            bus.best_dist <= '1;
            bus.motionx   <= '0;
            bus.motiony   <= '0;
            bus.err       <= 1'b0;
            count         <= '0;
          end
        end
        SEARCH: begin
          if (multihot && bus.compstart) bus.err <= 1'b1;
          if (s1_valid && better) begin
            bus.best_dist <= s1_dist;
            bus.motionx   <= s1_x;
            bus.motiony   <= s1_y;
          end
          if (!bus.compstart) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end else if (s1_valid && (count == CNT_W'(NUM_CAND))) begin
            state      <= DONE;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b1;
            rearm_wait <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_me_min_select.sv
// Scoreboard bench for me_min_select: driver predicts each search result, monitor checks it on done.
module tb_me_min_select;
  localparam int NPE = 16, DIST_W = 16, VEC_W = 4, NUM_CAND = 256;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  me_min_select_if #(.NPE(NPE), .DIST_W(DIST_W), .VEC_W(VEC_W)) bus ();
  me_min_select #(.NPE(NPE), .DIST_W(DIST_W), .VEC_W(VEC_W), .NUM_CAND(NUM_CAND))
    dut (.clock(clock), .reset(reset), .bus(bus));

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  x;
    logic [3:0]  y;
    logic        e;
    int unsigned c;
  } exp_t;
  exp_t sbq[$];

  logic [15:0] acc_d[$];
  logic [3:0]  acc_x[$];
  logic [3:0]  acc_y[$];
  int          nacc;
  logic        err_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic int mag(input logic [3:0] v);
    int s;
    s = int'($signed(v));
    return (s < 0) ? -s : s;
  endfunction

  // Reference: minimum over all accepted candidates, then tie resolution among the minima.
  function automatic void model_best(output logic [15:0] bd, output logic [3:0] bx, output logic [3:0] by);
    int m;
    int bi;
    m  = 'hFFFF;
    bi = -1;
    bd = 16'hFFFF;
    bx = '0;
    by = '0;
    foreach (acc_d[i]) if (int'(acc_d[i]) < m) m = int'(acc_d[i]);
    if (m == 'hFFFF) return;
    foreach (acc_d[i]) begin
      if (int'(acc_d[i]) == m) begin
        if (bi < 0) bi = i;
`ifdef ME_TIE_CLOSEST_EN
        else if (mag(acc_x[i]) + mag(acc_y[i]) < mag(acc_x[bi]) + mag(acc_y[bi])) bi = i;
`endif
      end
    end
    bd = acc_d[bi];
    bx = acc_x[bi];
    by = acc_y[bi];
  endfunction

  function automatic logic [3:0] vx(input int k);
    return 4'((k % 16) - 8);
  endfunction

  function automatic logic [3:0] vy(input int k);
    return 4'((k / 16) - 8);
  endfunction

  function automatic logic [15:0] onehot(input int i);
    return 16'(1) << i;
  endfunction

  always @(negedge clock) begin
    if (reset === 1'b0 && bus.done === 1'b1) begin
      exp_t e;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: done=1 expected 0", cyc);
      end else begin
        e = sbq.pop_front();
        check("best_dist", 32'(bus.best_dist), 32'(e.d));
        check("motionx", 32'(bus.motionx), 32'(e.x));
        check("motiony", 32'(bus.motiony), 32'(e.y));
        check("err", 32'(bus.err), 32'(e.e));
        check("done_cycle", cyc, e.c);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic cs, input logic [15:0] pr, input logic [15:0] d,
                       input logic [3:0] x, input logic [3:0] y);
    step();
    bus.compstart = cs;
    bus.peready   = pr;
    bus.dist_in   = d;
    bus.vectorx   = x;
    bus.vectory   = y;
  endtask

  task automatic strobe(input logic [15:0] pr, input logic [15:0] d, input logic [3:0] x, input logic [3:0] y);
    exp_t e;
    drive(1'b1, pr, d, x, y);
    if (pr != '0 && (pr & (pr - 16'd1)) == '0) begin
      if (nacc < NUM_CAND) begin
        acc_d.push_back(d);
        acc_x.push_back(x);
        acc_y.push_back(y);
        nacc++;
        if (nacc == NUM_CAND) begin
          model_best(e.d, e.x, e.y);
          e.e = err_exp;
          e.c = cyc + 2;
          sbq.push_back(e);
        end
      end
    end else if (pr != '0) begin
      err_exp = 1'b1;
    end
  endtask

  task automatic begin_search();
    acc_d.delete();
    acc_x.delete();
    acc_y.delete();
    nacc    = 0;
    err_exp = 1'b0;
    drive(1'b0, '0, '0, '0, '0);
    drive(1'b1, '0, '0, '0, '0);
  endtask

  task automatic finish_search(input string tag);
    for (int i = 0; i < 5; i++) drive(1'b1, '0, '0, '0, '0);
    // compstart still high after done: must not restart
    check({tag, "_hold_busy"}, 32'(bus.busy), 32'd0);
    drive(1'b0, '0, '0, '0, '0);
  endtask

  initial begin
    logic [15:0] bd;
    logic [3:0]  bx;
    logic [3:0]  by;
    int          r;

    reset         = 1'b1;
    bus.compstart = 1'b0;
    bus.peready   = '0;
    bus.dist_in   = '0;
    bus.vectorx   = '0;
    bus.vectory   = '0;
    step();
    step();
    check("rst_best_dist", 32'(bus.best_dist), 32'hFFFF);
    check("rst_motionx", 32'(bus.motionx), 32'd0);
    check("rst_motiony", 32'(bus.motiony), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;

    // strictly decreasing distortion
    begin_search();
    for (int k = 0; k < NUM_CAND; k++) begin
      strobe(onehot(k % 16), 16'(1000 - k), vx(k), vy(k));
      if (k == 100) check("busy_mid", 32'(bus.busy), 32'd1);
    end
    finish_search("decr");

    // single minimum at (-8,-8)
    begin_search();
    for (int k = 0; k < NUM_CAND; k++) strobe(onehot(k % 16), (k == 0) ? 16'd3 : 16'd500, vx(k), vy(k));
    finish_search("single");

    // all equal
    begin_search();
    for (int k = 0; k < NUM_CAND; k++) strobe(onehot((k * 5) % 16), 16'd200, vx(k), vy(k));
    finish_search("ties");

    // multi-hot strobe carrying dist 0 is ignored and not counted
    begin_search();
    for (int k = 0; k <= NUM_CAND; k++) begin
      if (k == 10) strobe(16'h0003, 16'd0, vx(k), vy(k));
      else strobe(onehot(k % 16), 16'd50, vx(k), vy(k));
    end
    finish_search("multihot");

    // abort after 100 strobes, then restart
    begin_search();
    for (int k = 0; k < 100; k++) strobe(onehot(k % 16), 16'($urandom_range(20, 900)), vx(k), vy(k));
    drive(1'b1, '0, '0, '0, '0);
    drive(1'b0, '0, '0, '0, '0);
    step();
    model_best(bd, bx, by);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_best_dist", 32'(bus.best_dist), 32'(bd));
    check("abort_motionx", 32'(bus.motionx), 32'(bx));
    check("abort_motiony", 32'(bus.motiony), 32'(by));
    bus.compstart = 1'b1;
    step();
    check("restart_best_dist", 32'(bus.best_dist), 32'hFFFF);
    check("restart_busy", 32'(bus.busy), 32'd1);
    drive(1'b0, '0, '0, '0, '0);
    drive(1'b0, '0, '0, '0, '0);

    // reset during the 50th strobe
    begin_search();
    for (int k = 0; k < 49; k++) strobe(onehot(k % 16), 16'(300 - k), vx(k), vy(k));
    strobe(onehot(3), 16'd1, vx(49), vy(49));
    reset = 1'b1;
    step();
    check("midrst_best_dist", 32'(bus.best_dist), 32'hFFFF);
    check("midrst_motion", 32'({bus.motionx, bus.motiony}), 32'd0);
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_err", 32'(bus.err), 32'd0);
    reset         = 1'b0;
    bus.compstart = 1'b0;
    bus.peready   = '0;
    drive(1'b0, '0, '0, '0, '0);

    // randomized searches with gaps, occasional multi-hot, and one late strobe
    for (int s = 0; s < 3; s++) begin
      begin_search();
      while (nacc < NUM_CAND) begin
        r = $urandom_range(0, 99);
        if (r < 10) drive(1'b1, '0, 16'($urandom), 4'($urandom), 4'($urandom));
        else if (r < 13) strobe(16'h0101 << $urandom_range(0, 7), 16'($urandom_range(0, 50)),
                                4'($urandom), 4'($urandom));
        else strobe(onehot($urandom_range(0, 15)), 16'($urandom_range(100, 400)),
                    4'($urandom), 4'($urandom));
      end
      strobe(onehot(0), 16'd0, 4'd0, 4'd0);
      finish_search("rand");
    end

    for (int i = 0; i < 5; i++) step();
    while (sbq.size() != 0) begin
      void'(sbq.pop_front());
      checks++;
      errors++;
      $display("FAIL missing_done: done=0 expected 1");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end
endmodule
